// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: writeback, two read ports, issue/flush scoreboard control.
// The master side drives indices and strobes; the slave (register file) returns data and busy state.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_addr1;
  logic [ADDR_WIDTH-1:0] read_addr2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic                  read_busy1;
  logic                  read_busy2;
  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  flush;
  logic [ADDR_WIDTH:0]   pending_count;

  modport master (
    output write_en, write_addr, write_data,
    output read_addr1, read_addr2,
    output issue_en, issue_addr, flush,
    input  read_data1, read_data2, read_busy1, read_busy2, pending_count
  );

  modport slave (
    input  write_en, write_addr, write_data,
    input  read_addr1, read_addr2,
    input  issue_en, issue_addr, flush,
    output read_data1, read_data2, read_busy1, read_busy2, pending_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, optional write bypass,
// and a busy-bit scoreboard with a registered count of in-flight destinations.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic               clk,
  input  logic               reset,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH:0]   pending;
  logic [ADDR_WIDTH:0]   pending_next;
  logic                  write_ok;
  logic                  issue_ok;
  logic                  fwd1;
  logic                  fwd2;

  assign write_ok = bus.write_en && !((ZERO_REG != 0) && (bus.write_addr == '0));
  assign issue_ok = bus.issue_en && !((ZERO_REG != 0) && (bus.issue_addr == '0));

  // Applied lowest priority first so that issue overrides flush, which overrides write.
  always_comb begin
    busy_next = busy;
    if (write_ok)
      busy_next[bus.write_addr] = 1'b0;
    if (bus.flush)
      busy_next = '0;
    if (issue_ok)
      busy_next[bus.issue_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_next[0] = 1'b0;
  end

  always_comb begin
    pending_next = '0;
    for (int i = 0; i < DEPTH; i++)
      pending_next = pending_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busy_next;
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (write_ok) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  assign fwd1 = (BYPASS != 0) && write_ok && (bus.write_addr == bus.read_addr1);
  assign fwd2 = (BYPASS != 0) && write_ok && (bus.write_addr == bus.read_addr2);

  // Reset gating keeps a forwarded write from leaking out while reset is held.
  always_comb begin
    bus.read_data1 = fwd1 ? bus.write_data : regs[bus.read_addr1];
    if (reset || ((ZERO_REG != 0) && (bus.read_addr1 == '0)))
      bus.read_data1 = '0;
    bus.read_data2 = fwd2 ? bus.write_data : regs[bus.read_addr2];
    if (reset || ((ZERO_REG != 0) && (bus.read_addr2 == '0)))
      bus.read_data2 = '0;
  end

  assign bus.read_busy1    = busy[bus.read_addr1] && !fwd1 && !reset;
  assign bus.read_busy2    = busy[bus.read_addr2] && !fwd2 && !reset;
  assign bus.pending_count = pending;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven scoreboard bench for regfile_scoreboard; a BYPASS=0 twin shares
// the stimulus so forwarding can be compared against the delayed-visibility case.
module tb_regfile_scoreboard;
  logic clk;
  logic reset;

  regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nb ();

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .bus(bus_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        rb1;
    logic        rb2;
    logic [5:0]  pc;
    logic [31:0] nb;
    bit          chk_data;
    bit          chk_nb;
  } vec_t;

  vec_t tbl [19];
  vec_t exp_q [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic ie, input logic [4:0] ia, input logic fl,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic rb1, input logic rb2, input logic [5:0] pc,
                              input logic [31:0] nb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2;
    v.ie = ie; v.ia = ia; v.fl = fl;
    v.rd1 = rd1; v.rd2 = rd2; v.rb1 = rb1; v.rb2 = rb2; v.pc = pc; v.nb = nb;
    v.chk_data = 1'b1;
    v.chk_nb   = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.write_en    = v.we;  bus_nb.write_en    = v.we;
    bus.write_addr  = v.wa;  bus_nb.write_addr  = v.wa;
    bus.write_data  = v.wd;  bus_nb.write_data  = v.wd;
    bus.read_addr1  = v.ra1; bus_nb.read_addr1  = v.ra1;
    bus.read_addr2  = v.ra2; bus_nb.read_addr2  = v.ra2;
    bus.issue_en    = v.ie;  bus_nb.issue_en    = v.ie;
    bus.issue_addr  = v.ia;  bus_nb.issue_addr  = v.ia;
    bus.flush       = v.fl;  bus_nb.flush       = v.fl;
  endtask

  task automatic check_output();
    vec_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (e.chk_data) begin
      check("read_data1", bus.read_data1, e.rd1);
      check("read_data2", bus.read_data2, e.rd2);
    end
    if (e.chk_nb)
      check("nobypass_read_data1", bus_nb.read_data1, e.nb);
    check("read_busy1", 32'(bus.read_busy1), 32'(e.rb1));
    check("read_busy2", 32'(bus.read_busy2), 32'(e.rb2));
    check("pending_count", 32'(bus.pending_count), 32'(e.pc));
  endtask

  // Drive just after the edge, sample combinational outputs at the falling edge.
  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    check_output();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t v;

    tbl[0]  = mk(0, 0,  0,            5,  5,  0, 0,  0, 0,            0,            0, 0, 0, 0);
    tbl[1]  = mk(1, 5,  32'hDEADBEEF, 5,  5,  0, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0,  0,            5,  0,  0, 0,  0, 32'hDEADBEEF, 0,            0, 0, 0, 32'hDEADBEEF);
    tbl[3]  = mk(1, 0,  32'h1234,     0,  0,  0, 0,  0, 0,            0,            0, 0, 0, 0);
    tbl[4]  = mk(0, 0,  0,            0,  0,  0, 0,  0, 0,            0,            0, 0, 0, 0);
    tbl[5]  = mk(0, 0,  0,            8,  9,  1, 8,  0, 0,            0,            0, 0, 0, 0);
    tbl[6]  = mk(0, 0,  0,            8,  9,  1, 9,  0, 0,            0,            1, 0, 1, 0);
    tbl[7]  = mk(1, 8,  32'h88,       8,  9,  0, 0,  0, 32'h88,       0,            0, 1, 2, 0);
    tbl[8]  = mk(0, 0,  0,            8,  9,  0, 0,  0, 32'h88,       0,            0, 1, 1, 32'h88);
    tbl[9]  = mk(0, 0,  0,            3,  7,  1, 3,  0, 0,            0,            0, 0, 1, 0);
    tbl[10] = mk(0, 0,  0,            3,  7,  1, 7,  0, 0,            0,            1, 0, 2, 0);
    tbl[11] = mk(1, 3,  32'h33,       3,  7,  1, 3,  0, 32'h33,       0,            0, 1, 3, 0);
    tbl[12] = mk(1, 7,  32'h77,       3,  7,  1, 4,  0, 32'h33,       32'h77,       1, 0, 3, 32'h33);
    tbl[13] = mk(0, 0,  0,            4,  7,  0, 0,  0, 0,            32'h77,       1, 0, 3, 0);
    tbl[14] = mk(0, 0,  0,            10, 9,  1, 10, 1, 0,            0,            0, 1, 3, 0);
    tbl[15] = mk(0, 0,  0,            10, 9,  1, 0,  0, 0,            0,            1, 0, 1, 0);
    tbl[16] = mk(0, 0,  0,            0,  10, 0, 0,  0, 0,            0,            0, 1, 1, 0);
    tbl[17] = mk(0, 0,  0,            10, 0,  1, 10, 0, 0,            0,            1, 0, 1, 0);
    tbl[18] = mk(0, 0,  0,            10, 0,  0, 0,  0, 0,            0,            1, 0, 1, 0);

    reset = 1'b1;
    drive(mk(1, 5, 32'hFFFF_FFFF, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0));
    #3;
    check("reset_read_data1", bus.read_data1, 32'h0);
    check("reset_read_busy1", 32'(bus.read_busy1), 32'h0);
    check("reset_pending", 32'(bus.pending_count), 32'h0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 19; i++)
      apply_stimulus(tbl[i]);

    // Clear r10, then fill every register and drain it again.
    apply_stimulus(mk(0, 0, 0, 10, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
    for (int i = 1; i < 32; i++) begin
      v = mk(0, 0, 0, 5'(i), 5'(i - 1), 1, 5'(i), 0, 0, 0, 0, (i > 1), 6'(i - 1), 0);
      v.chk_data = 1'b0;
      v.chk_nb   = 1'b0;
      apply_stimulus(v);
    end
    v = mk(0, 0, 0, 31, 1, 0, 0, 0, 0, 0, 1, 1, 31, 0);
    v.chk_data = 1'b0;
    v.chk_nb   = 1'b0;
    apply_stimulus(v);
    for (int i = 1; i < 32; i++) begin
      v = mk(1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i), 0, 0, 0,
             32'(i) * 32'h01010101, 32'(i) * 32'h01010101, 0, 0, 6'(32 - i), 0);
      v.chk_nb = 1'b0;
      apply_stimulus(v);
    end
    apply_stimulus(mk(0, 0, 0, 5, 31, 0, 0, 0, 32'h05050505, 32'h1F1F1F1F, 0, 0, 0, 32'h05050505));

    // Asynchronous reset in the middle of a cycle with a forwarded write in flight.
    apply_stimulus(mk(0, 0, 0, 12, 0, 1, 12, 0, 32'h0C0C0C0C, 0, 0, 0, 0, 32'h0C0C0C0C));
    @(posedge clk);
    #1;
    drive(mk(1, 12, 32'hAAAA, 12, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("premid_read_data1", bus.read_data1, 32'hAAAA);
    check("premid_read_data2", bus.read_data2, 32'h05050505);
    check("premid_pending", 32'(bus.pending_count), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_read_data1", bus.read_data1, 32'h0);
    check("midreset_read_data2", bus.read_data2, 32'h0);
    check("midreset_nb_read_data2", bus_nb.read_data2, 32'h0);
    check("midreset_pending", 32'(bus.pending_count), 32'h0);
    check("midreset_busy1", 32'(bus.read_busy1), 32'h0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 32; a++)
      apply_stimulus(mk(0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the pipelined MIPS datapath. It has configurable width and depth, one write port, two combinational read ports, optional write-to-read bypass and a hardwired zero register. An integrated busy-bit scoreboard tracks in-flight destination registers so decode can detect RAW hazards. A pending counter lets hazard/flush logic see how many writes are outstanding.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and issues
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
write_en  input  1  writeback strobe
write_addr  input  ADDR_WIDTH  writeback destination
write_data  input  DATA_WIDTH  writeback value
read_addr1  input  ADDR_WIDTH  read port 1 index
read_addr2  input  ADDR_WIDTH  read port 2 index
read_data1  output  DATA_WIDTH  read port 1 data (combinational)
read_data2  output  DATA_WIDTH  read port 2 data (combinational)
read_busy1  output  1  read_addr1 has an outstanding producer
read_busy2  output  1  read_addr2 has an outstanding producer
issue_en  input  1  instruction with destination issued this cycle
issue_addr  input  ADDR_WIDTH  destination being issued
flush  input  1  clear all busy bits (pipeline squash)
pending_count  output  ADDR_WIDTH+1  number of set busy bits

Behaviour:
- Reset (async, active-high): all registers = 0, all busy bits = 0, pending_count = 0. read_data* = 0 and read_busy* = 0 while reset is held.
- Write: on posedge clk with write_en=1, reg[write_addr] <= write_data. Write latency is 1 cycle. With ZERO_REG=1, writes to address 0 are dropped.
- Read: read_data = reg[read_addr] combinationally. With ZERO_REG=1, address 0 always returns 0.
- Bypass (BYPASS=1): if write_en=1, read_addrN==write_addr and the address is not a dropped zero-write, read_dataN = write_data in the same cycle. With BYPASS=0, new data is visible the cycle after the write.
- Busy bits, per-register flag, updated on posedge clk:
  - issue_en=1 sets busy[issue_addr].
  - write_en=1 clears busy[write_addr].
  - flush=1 clears all bits.
  - Priority, highest first: issue set > flush > write clear. Issue and write to the same address in one cycle leave the bit set, because the newer producer wins. Flush together with issue leaves only issue_addr set.
  - With ZERO_REG=1, busy[0] is constant 0 and issues to address 0 are ignored.
  - A write to a non-busy register is legal: data is written and the busy bit stays 0.
  - An issue to an already-busy register is legal: the bit stays 1 and the count does not change.
- read_busyN = busy[read_addrN]. With BYPASS=1 it is masked to 0 when write_en=1 and write_addr==read_addrN in the same cycle, since the data is being forwarded.
- pending_count is a registered count of set busy bits, updated in the same edge as the bits. It equals popcount(busy) at all times after the edge, with no drift under simultaneous set/clear of different addresses.
  - Implementation is either incremental (+1 new set, −1 clear of a set bit, net 0 for same-address set+clear) or a registered popcount.
  - Maximum value is 2**ADDR_WIDTH (2**ADDR_WIDTH − 1 with ZERO_REG=1); it never wraps.
- Reset asserted mid-operation immediately clears data, busy bits and count. Inputs are ignored until the first posedge after reset deasserts.
- Read ports are independent: both may address the same register, or the register being written.

Test Plan:
- Reset, then read all 32 addresses on both ports → all 0, read_busy* = 0, pending_count = 0. Assert reset mid-run after writes → immediate 0s.
- Write 0xDEADBEEF to r5, read r5 same cycle with BYPASS=1 → 0xDEADBEEF. BYPASS=0 → old value 0 that cycle, 0xDEADBEEF the next. Write 0x1234 to r0 → r0 reads 0 on both ports.
- Issue r8, r9 on consecutive cycles → pending_count 1 then 2, read_busy1(r8)=1. Writeback r8 → read_busy masked in the same cycle, bit clear and pending_count=1 the next cycle.
- Same cycle: issue r3 and write r3 (r3 busy beforehand) → r3 stays busy, count unchanged. Issue r4 with write r7 (busy) → count net 0.
- Set r1–r6 busy (count 6), then flush with issue r10 → only r10 busy, pending_count = 1. Issue r0 → ignored, count unchanged.
- Issue every register r1–r31 → pending_count = 31, no wrap. Writeback all → count returns to 0.
